// File: rtl/cmp_pkg.sv
// Shared types for the comparator window monitor: FSM states, the comparator
// flag bundle, the sample class index and the reference flag function.
package cmp_pkg;

  typedef enum logic {
    ACCUM  = 1'b0,
    REPORT = 1'b1
  } state_t;

  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } cmp_flags_t;

  typedef enum logic [1:0] {
    CLS_EQ = 2'd0,
    CLS_GT = 2'd1,
    CLS_LT = 2'd2
  } cmp_cls_t;

  // Flags a correct comparator must produce for (a, b), unsigned compare.
  // Operands arrive zero-extended so one function serves any width up to 32.
  function automatic cmp_flags_t exp_flags(input logic [31:0] a,
                                           input logic [31:0] b);
    cmp_flags_t f;
    f.eq = (a == b);
    f.gt = (a > b);
    f.lt = (a < b);
    return f;
  endfunction

endpackage

// File: rtl/cmp_sample_check.sv
// Combinational per-sample checker: validates the comparator flags against
// the true relation of a and b, classifies the sample and computes |a-b|.
module cmp_sample_check
  import cmp_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  cmp_flags_t       flags,
  output logic             err,
  output cmp_cls_t         cls,
  output logic [WIDTH-1:0] gap
);

  cmp_flags_t exp;

  // Error when the flags are not one-hot or disagree with the real relation.
  always_comb begin
    exp = exp_flags(32'(a), 32'(b));
    err = !$onehot(flags) || (flags != exp);
  end

  // Class index is only meaningful for non-error samples, where flags are one-hot.
  always_comb begin
    cls = CLS_EQ;
    if (flags.gt) begin
      cls = CLS_GT;
    end else if (flags.lt) begin
      cls = CLS_LT;
    end
  end

  // Larger minus smaller never wraps, so the gap fits in WIDTH bits.
  always_comb begin
    gap = (a > b) ? (a - b) : (b - a);
  end

endmodule

// File: rtl/cmp_window_monitor.sv
// Windowed monitor behind the 4-bit magnitude comparator. Counts correct
// eq/gt/lt outcomes and erroneous samples over WIN accepted samples, tracks
// the largest |a-b| and holds a report until the consumer takes it.
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   ACCUM  | accepting samples, fields show live partial counts
//   REPORT | window complete, fields frozen, waiting for rep_ready
module cmp_window_monitor
  import cmp_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int WIN   = 16,
  parameter int CNT_W = $clog2(WIN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             eq,
  input  logic             gt,
  input  logic             lt,
  output logic             rep_valid,
  input  logic             rep_ready,
  output logic [CNT_W-1:0] n_eq,
  output logic [CNT_W-1:0] n_gt,
  output logic [CNT_W-1:0] n_lt,
  output logic [CNT_W-1:0] n_err,
  output logic [WIDTH-1:0] max_gap
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] smp_q, smp_d;
  logic [CNT_W-1:0] n_eq_q, n_eq_d;
  logic [CNT_W-1:0] n_gt_q, n_gt_d;
  logic [CNT_W-1:0] n_lt_q, n_lt_d;
  logic [CNT_W-1:0] n_err_q, n_err_d;
  logic [WIDTH-1:0] max_gap_q, max_gap_d;

  cmp_flags_t       flags;
  logic             s_err;
  cmp_cls_t         s_cls;
  logic [WIDTH-1:0] s_gap;
  logic             accept;

  assign flags = '{eq: eq, gt: gt, lt: lt};

  cmp_sample_check #(
    .WIDTH (WIDTH)
  ) u_check (
    .a     (a),
    .b     (b),
    .flags (flags),
    .err   (s_err),
    .cls   (s_cls),
    .gap   (s_gap)
  );

  // Ready depends only on registered state and reset, never on in_valid;
  // gating with rst keeps it low during the reset cycle itself.
  assign in_ready  = (state_q == ACCUM) && !rst;
  assign rep_valid = (state_q == REPORT);
  assign accept    = in_valid && in_ready;

  // Next-state, counter and max-gap update.
  always_comb begin
    state_d   = state_q;
    smp_d     = smp_q;
    n_eq_d    = n_eq_q;
    n_gt_d    = n_gt_q;
    n_lt_d    = n_lt_q;
    n_err_d   = n_err_q;
    max_gap_d = max_gap_q;
    unique case (state_q)
      ACCUM: begin
        if (accept) begin
          smp_d = smp_q + CNT_W'(1);
          if (s_err) begin
            n_err_d = n_err_q + CNT_W'(1);
          end else begin
            unique case (s_cls)
              CLS_GT:  n_gt_d = n_gt_q + CNT_W'(1);
              CLS_LT:  n_lt_d = n_lt_q + CNT_W'(1);
              default: n_eq_d = n_eq_q + CNT_W'(1);
            endcase
          end
          if (s_gap > max_gap_q) begin
            max_gap_d = s_gap;
          end
          if (smp_q == CNT_W'(WIN - 1)) begin
            state_d = REPORT;
          end
        end
      end
      REPORT: begin
        if (rep_ready) begin
          state_d   = ACCUM;
          smp_d     = '0;
          n_eq_d    = '0;
          n_gt_d    = '0;
          n_lt_d    = '0;
          n_err_d   = '0;
          max_gap_d = '0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACCUM;
      smp_q     <= '0;
      n_eq_q    <= '0;
      n_gt_q    <= '0;
      n_lt_q    <= '0;
      n_err_q   <= '0;
      max_gap_q <= '0;
    end else begin
      state_q   <= state_d;
      smp_q     <= smp_d;
      n_eq_q    <= n_eq_d;
      n_gt_q    <= n_gt_d;
      n_lt_q    <= n_lt_d;
      n_err_q   <= n_err_d;
      max_gap_q <= max_gap_d;
    end
  end

  assign n_eq    = n_eq_q;
  assign n_gt    = n_gt_q;
  assign n_lt    = n_lt_q;
  assign n_err   = n_err_q;
  assign max_gap = max_gap_q;

endmodule

// File: tb/tb_cmp_window_monitor.sv
// Self-checking bench for cmp_window_monitor: directed windows from the test
// plan followed by randomized traffic, all checked against a count model.
module tb_cmp_window_monitor;

  localparam int WIDTH = 4;
  localparam int WIN   = 16;
  localparam int CNT_W = $clog2(WIN + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b;
  logic             eq, gt, lt;
  logic             rep_valid;
  logic             rep_ready;
  logic [CNT_W-1:0] n_eq, n_gt, n_lt, n_err;
  logic [WIDTH-1:0] max_gap;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  int m_eq, m_gt, m_lt, m_err, m_gap, m_n;
  bit m_rep;

  cmp_window_monitor #(
    .WIDTH (WIDTH),
    .WIN   (WIN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .eq        (eq),
    .gt        (gt),
    .lt        (lt),
    .rep_valid (rep_valid),
    .rep_ready (rep_ready),
    .n_eq      (n_eq),
    .n_gt      (n_gt),
    .n_lt      (n_lt),
    .n_err     (n_err),
    .max_gap   (max_gap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_eq = 0; m_gt = 0; m_lt = 0; m_err = 0; m_gap = 0; m_n = 0; m_rep = 0;
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ":rep_valid"}, int'(rep_valid), int'(m_rep));
    chk({ctx, ":in_ready"}, int'(in_ready), int'(!m_rep && !rst));
    chk({ctx, ":n_eq"}, int'(n_eq), m_eq);
    chk({ctx, ":n_gt"}, int'(n_gt), m_gt);
    chk({ctx, ":n_lt"}, int'(n_lt), m_lt);
    chk({ctx, ":n_err"}, int'(n_err), m_err);
    chk({ctx, ":max_gap"}, int'(max_gap), m_gap);
    if (rep_valid) begin
      chk({ctx, ":sum"}, int'(n_eq) + int'(n_gt) + int'(n_lt) + int'(n_err), WIN);
    end
  endtask

  // One clock: drive at the falling edge, update the model at the rising
  // edge, then check at the next falling edge. fi is {eq, gt, lt}.
  task automatic step(input bit iv, input int ai, input int bi,
                      input logic [2:0] fi, input bit rr, input string ctx);
    bit acc, take;
    logic [2:0] ef;
    int g;
    in_valid  = iv;
    a         = WIDTH'(ai);
    b         = WIDTH'(bi);
    {eq, gt, lt} = fi;
    rep_ready = rr;
    acc  = iv && !m_rep && !rst;
    take = m_rep && rr && !rst;
    @(posedge clk);
    if (acc) begin
      ef = {ai == bi, ai > bi, ai < bi};
      if ($countones(fi) != 1 || fi != ef) m_err++;
      else if (fi[2]) m_eq++;
      else if (fi[1]) m_gt++;
      else m_lt++;
      g = (ai > bi) ? ai - bi : bi - ai;
      if (g > m_gap) m_gap = g;
      m_n++;
      if (m_n == WIN) m_rep = 1;
    end
    if (take) model_clear();
    @(negedge clk);
    check_all(ctx);
  endtask

  task automatic pulse_reset(input string ctx);
    rst      = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    model_clear();
    @(negedge clk);
    check_all(ctx);
    rst      = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
    eq = 1'b0; gt = 1'b0; lt = 1'b0; rep_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all("reset");
    rst = 1'b0;

    // uniform window
    for (int i = 0; i < WIN; i++) step(1, 5, 3, 3'b010, 0, "uni");
    chk("uni:rv", int'(rep_valid), 1);
    chk("uni:ngt", int'(n_gt), 16);
    chk("uni:gap", int'(max_gap), 2);

    // backpressure with in_valid high
    for (int i = 0; i < 5; i++) step(1, 1, 2, 3'b001, 0, "bp");
    chk("bp:ngt_held", int'(n_gt), 16);
    step(1, 1, 2, 3'b001, 1, "bp_rel");
    chk("bp_rel:ngt", int'(n_gt), 0);
    chk("bp_rel:ready", int'(in_ready), 1);

    // mixed window
    for (int i = 0; i < 4; i++) step(1, 7, 7, 3'b100, 0, "mix");
    for (int i = 0; i < 6; i++) step(1, 9, 2, 3'b010, 0, "mix");
    for (int i = 0; i < 6; i++) step(1, 1, 15, 3'b001, 0, "mix");
    chk("mix:neq", int'(n_eq), 4);
    chk("mix:ngt", int'(n_gt), 6);
    chk("mix:nlt", int'(n_lt), 6);
    chk("mix:nerr", int'(n_err), 0);
    chk("mix:gap", int'(max_gap), 14);
    step(0, 0, 0, 3'b000, 1, "mix_rel");

    // error detection
    for (int i = 0; i < 14; i++) step(1, 0, 0, 3'b100, 0, "err");
    step(1, 4, 4, 3'b110, 0, "err");
    step(1, 3, 8, 3'b010, 0, "err");
    chk("err:nerr", int'(n_err), 2);
    chk("err:neq", int'(n_eq), 14);
    chk("err:gap", int'(max_gap), 5);
    step(0, 0, 0, 3'b000, 1, "err_rel");

    // bubbles between accepts
    for (int i = 0; i < WIN; i++) begin
      step(0, 12, 0, 3'b010, 0, "bub_idle");
      step(1, i % 16, 6, (i % 16 == 6) ? 3'b100 : (i % 16 > 6) ? 3'b010 : 3'b001,
           0, "bub");
    end
    chk("bub:rv", int'(rep_valid), 1);
    chk("bub:gap", int'(max_gap), 9);
    step(0, 0, 0, 3'b000, 1, "bub_rel");

    // reset mid-window
    for (int i = 0; i < 7; i++) step(1, 2, 9, 3'b001, 0, "mid");
    pulse_reset("mid_rst");
    for (int i = 0; i < WIN; i++) step(1, 8, 8, 3'b100, 0, "post");
    chk("post:neq", int'(n_eq), 16);
    chk("post:nlt", int'(n_lt), 0);
    step(0, 0, 0, 3'b000, 1, "post_rel");

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      int ra, rb;
      logic [2:0] rf;
      ra = int'($urandom_range(0, 15));
      rb = ($urandom_range(0, 3) == 0) ? ra : int'($urandom_range(0, 15));
      if ($urandom_range(0, 6) != 0) rf = {ra == rb, ra > rb, ra < rb};
      else rf = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 199) == 0) pulse_reset("rnd_rst");
      else step($urandom_range(0, 3) != 0, ra, rb, rf, $urandom_range(0, 1) == 1, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cmp_window_monitor.md
# cmp_window_monitor

Windowed result monitor placed directly downstream of the 4-bit magnitude comparator. It consumes each operand pair (a, b) together with the comparator's eq/gt/lt flags under a valid/ready handshake. Over a fixed window of samples it counts equal/greater/less outcomes and flags any sample whose flags are not one-hot or disagree with the true a/b relation. At window end it presents a held report through a second valid/ready handshake.

## Interface
- WIDTH, 4: operand width in bits.
- WIN, 16: samples per report window, ≥ 2.
- CNT_W, $clog2(WIN+1): width of each count field.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  sample present.
- in_ready  out  1  monitor accepts a sample.
- a, b  in  WIDTH each  operands presented to the comparator.
- eq, gt, lt  in  1 each  comparator flags for (a, b).
- rep_valid  out  1  report fields valid and held.
- rep_ready  in  1  report consumer accepts.
- n_eq, n_gt, n_lt  out  CNT_W each  correct-sample counts per class.
- n_err  out  CNT_W  erroneous-sample count.
- max_gap  out  WIDTH  largest |a−b| over all accepted samples in the window, erroneous ones included.

## Operation
- Accept condition: a sample is accepted when in_valid && in_ready. No other sample affects state.
- Per-sample check:
  - Expected flags are {a==b, a>b, a<b}, compared unsigned.
  - err = flags not exactly one-hot OR flags ≠ expected.
  - An err sample increments n_err only.
  - Otherwise exactly one of n_eq, n_gt or n_lt increments.
- Gap: |a−b| is computed at WIDTH bits with no overflow (larger minus smaller). max_gap = max(max_gap, gap).
- FSM states:
  - ACCUM: in_ready = 1, rep_valid = 0. An internal sample counter counts accepted samples. When the WIN-th sample is accepted, the FSM moves to REPORT.
  - REPORT: in_ready = 0, rep_valid = 1. All report fields are held stable. On rep_ready the FSM returns to ACCUM, and all counters, max_gap and the sample counter clear to 0 on that edge.
- rep_ready is ignored in ACCUM. in_valid is ignored in REPORT.
- Invariant at rep_valid: n_eq + n_gt + n_lt + n_err == WIN.
- Count fields never exceed WIN, so they need no saturation.

## Timing
- Reset values: in_ready = 0 during the reset cycle. From the first cycle after rst deasserts, in_ready = 1. rep_valid, n_eq, n_gt, n_lt, n_err and max_gap reset to 0. The FSM resets to ACCUM.
- Counts and max_gap update on the edge that accepts the sample. The outputs show live partial values while in ACCUM; consumers must only use them while rep_valid = 1.
- rep_valid rises in the cycle after the WIN-th accept.
- After the rep_valid && rep_ready edge: rep_valid = 0 and all fields = 0. The earliest next accept is in that same following cycle.
- Minimum period is WIN + 1 cycles per window.
- Reset mid-window or during REPORT discards all partial state on that edge. The next report requires WIN fresh samples.
- No combinational path from in_valid to in_ready. No combinational path from rep_ready to rep_valid.

## Structure
- Package cmp_pkg holds:
  - state enum {ACCUM, REPORT};
  - the packed flag typedef cmp_flags_t {eq, gt, lt};
  - function exp_flags(a, b) returning cmp_flags_t.
- Sub-module cmp_sample_check is purely combinational:
  - inputs a, b, flags;
  - outputs err, cls (eq/gt/lt index) and gap.
- The top level holds the FSM, the counters and max_gap.

## Test plan
- Uniform window: 16 samples with a=5, b=3, gt=1. Expect rep_valid next cycle with n_gt=16, n_eq=n_lt=n_err=0, max_gap=2.
- Mixed window:
  - 4 samples a=b=7, eq=1;
  - 6 samples a=9, b=2, gt=1;
  - 6 samples a=1, b=15, lt=1.
  - Expect n_eq=4, n_gt=6, n_lt=6, n_err=0, max_gap=14.
- Error detection: 14 correct eq samples (a=b=0), plus one sample a=b=4 with eq=gt=1, plus one sample a=3, b=8 with gt=1. Expect n_err=2, n_eq=14, max_gap=5.
- Backpressure: rep_ready held low for 5 cycles with in_valid high. Expect in_ready=0 and fields stable throughout. Raise rep_ready; next cycle expect all fields 0 and in_ready=1.
- Bubbles: 16 samples interleaved with in_valid=0 cycles. Only accepted samples count, and the report appears one cycle after the 16th accept.
- Reset mid-window: pulse rst after 7 samples. Expect all outputs 0; the next report requires 16 new samples and shows counts from them only.
